// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one 32-bit memory port between the fetch stage
//            (instruction reads) and the mem stage (data loads/stores).
//            Each access is a request/ready handshake with a memory of
//            variable latency. The data side normally wins, but after
//            STARVE_LIMIT data grants with a fetch waiting, the fetch goes next.
// Ports    : clk, rst (async, active-low)
//            inst_req/inst_addr        -> inst_done/inst_rdata
//            data_req/data_wr/data_wstrb/data_addr/data_wdata
//                                      -> data_done/data_rdata
//            mem_req/mem_wr/mem_wstrb/mem_addr/mem_wdata (registered)
//            mem_rdata/mem_ready (from memory), mem_err (abort pulse)
// Options  : MEM_ARB_TIMEOUT_EN - abort an access after TIMEOUT_CYCLES cycles
//            without mem_ready. The done pulse then comes with mem_err, and
//            the owner's read data becomes zero.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_done,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_err
);

  localparam logic [3:0] c_starveLimit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_starveCnt;
  logic        r_instDone;
  logic        r_dataDone;
  logic [31:0] r_instRdata;
  logic [31:0] r_dataRdata;
  logic        r_memReq;
  logic        r_memWr;
  logic [3:0]  r_memWstrb;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWdata;

  logic w_starveHit;
  logic w_grantData;
  logic w_grantInst;
  logic w_abort;
  logic w_finish;

  // A fetch that has waited through STARVE_LIMIT data grants goes first.
  assign w_starveHit = inst_req && (r_starveCnt == c_starveLimit);
  assign w_grantData = data_req && !w_starveHit;
  assign w_grantInst = inst_req && !w_grantData;
  assign w_finish    = mem_ready || w_abort;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] c_timeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_waitCnt;
  logic       r_memErr;

  // The counter starts at 0 in the first cycle mem_req is high. An abort
  // therefore happens after exactly TIMEOUT_CYCLES cycles of mem_req.
  assign w_abort = !mem_ready && (r_waitCnt == c_timeoutLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_waitCnt <= 8'd0;
      r_memErr  <= 1'b0;
    end else begin
      r_memErr <= ((r_state == DATA) || (r_state == INST)) && w_abort;
      if ((r_state == DATA) || (r_state == INST))
        r_waitCnt <= r_waitCnt + 8'd1;
      else
        r_waitCnt <= 8'd0;
    end
  end

  assign mem_err = r_memErr;
`else
  assign w_abort = 1'b0;
  assign mem_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_grantData)
          w_nextState = DATA;
        else if (w_grantInst)
          w_nextState = INST;
      end
      DATA, INST: begin
        if (w_finish)
          w_nextState = RESP;
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Memory-port registers, read-data holding registers, done pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starveCnt <= 4'd0;
      r_instDone  <= 1'b0;
      r_dataDone  <= 1'b0;
      r_instRdata <= 32'h0;
      r_dataRdata <= 32'h0;
      r_memReq    <= 1'b0;
      r_memWr     <= 1'b0;
      r_memWstrb  <= 4'h0;
      r_memAddr   <= 32'h0;
      r_memWdata  <= 32'h0;
    end else begin
      // Done is set on the edge into RESP, so it is high only during RESP.
      r_instDone <= 1'b0;
      r_dataDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!inst_req || w_grantInst)
            r_starveCnt <= 4'd0;
          else if (w_grantData && (r_starveCnt != c_starveLimit))
            r_starveCnt <= r_starveCnt + 4'd1;

          if (w_grantData) begin
            r_memReq   <= 1'b1;
            r_memWr    <= data_wr;
            r_memWstrb <= data_wr ? data_wstrb : 4'h0;
            r_memAddr  <= data_addr;
            r_memWdata <= data_wdata;
          end else if (w_grantInst) begin
            r_memReq   <= 1'b1;
            r_memWr    <= 1'b0;
            r_memWstrb <= 4'h0;
            r_memAddr  <= inst_addr;
            r_memWdata <= 32'h0;
          end
        end
        DATA, INST: begin
          if (w_finish) begin
            r_memReq   <= 1'b0;
            r_memWr    <= 1'b0;
            r_memWstrb <= 4'h0;
            if (r_state == DATA) begin
              r_dataDone <= 1'b1;
              // An aborted access returns zero. A completed store leaves
              // the load data register unchanged.
              if (!mem_ready)
                r_dataRdata <= 32'h0;
              else if (!r_memWr)
                r_dataRdata <= mem_rdata;
            end else begin
              r_instDone  <= 1'b1;
              r_instRdata <= mem_ready ? mem_rdata : 32'h0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign inst_done  = r_instDone;
  assign inst_rdata = r_instRdata;
  assign data_done  = r_dataDone;
  assign data_rdata = r_dataRdata;
  assign mem_req    = r_memReq;
  assign mem_wr     = r_memWr;
  assign mem_wstrb  = r_memWstrb;
  assign mem_addr   = r_memAddr;
  assign mem_wdata  = r_memWdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. It applies a table of
//            single transactions, then hand-built starvation, reset and
//            back-to-back sequences (plus a timeout sequence when
//            MEM_ARB_TIMEOUT_EN is defined), and then random traffic
//            checked against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic        inst_done;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = 4'h0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic        data_done;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic        mem_err;

  int nVec = 0;
  int nBad = 0;

  initial forever #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_LIMIT(LIMIT)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_done(inst_done), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_done(data_done), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic failNow(input string nm);
    nVec++;
    nBad++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // One directed transaction: inputs plus expected latency and read data
  typedef struct {
    bit          isData;
    bit          wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waitCyc;
    logic [31:0] memRd;
    int          expLat;
    logic [31:0] expRd;
  } vec_t;

  vec_t tbl[5];

  // Start in an IDLE cycle (at a falling edge) with both requests low.
  // Latency is counted in cycles from the request cycle to the done cycle.
  task automatic runOne(input vec_t v);
    int cyc;
    int reqCyc;
    bit done;
    if (v.isData) begin
      data_req = 1'b1; data_wr = v.wr; data_wstrb = v.strb;
      data_addr = v.addr; data_wdata = v.wdata;
    end else begin
      inst_req = 1'b1; inst_addr = v.addr;
    end
    mem_ready = 1'b0;
    cyc = 0; reqCyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        reqCyc++;
        chk("tbl_addr", mem_addr, v.addr);
        chk("tbl_wr", 32'(mem_wr), 32'(v.isData & v.wr));
        chk("tbl_wstrb", 32'(mem_wstrb), (v.isData && v.wr) ? 32'(v.strb) : 32'h0);
        if (v.isData && v.wr) chk("tbl_wdata", mem_wdata, v.wdata);
        if (reqCyc == v.waitCyc + 1) begin
          mem_ready = 1'b1;
          mem_rdata = v.memRd;
        end
      end
      if (inst_done || data_done) begin
        done = 1'b1;
        chk("tbl_owner_done", 32'(v.isData ? data_done : inst_done), 32'h1);
        chk("tbl_other_done", 32'(v.isData ? inst_done : data_done), 32'h0);
        chk("tbl_latency", 32'(cyc), 32'(v.expLat));
        chk("tbl_rdata", v.isData ? data_rdata : inst_rdata, v.expRd);
        chk("tbl_req_at_done", 32'(mem_req), 32'h0);
        inst_req = 1'b0;
        data_req = 1'b0;
      end
    end
    if (!done) begin
      failNow("tbl_done_timeout");
      inst_req = 1'b0;
      data_req = 1'b0;
    end
    @(negedge clk);
    chk("tbl_single_done", {30'h0, inst_done, data_done}, 32'h0);
    chk("tbl_idle_req", 32'(mem_req), 32'h0);
  endtask

  // Both requesters held high: grants go D,D,D,D,I and repeat.
  task automatic starveTest();
    int grants;
    int cyc;
    bit prevReq;
    logic [31:0] exp;
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2000;
    grants = 0; cyc = 0; prevReq = 1'b0;
    while (grants < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mem_ready = mem_req;
      mem_rdata = $urandom;
      chk("starve_no_dual_done", 32'(inst_done & data_done), 32'h0);
      if (mem_req && !prevReq) begin
        exp = (grants % 5 == 4) ? 32'h0000_1000 : 32'h0000_2000;
        chk("starve_grant_order", mem_addr, exp);
        grants++;
      end
      prevReq = mem_req;
    end
    if (grants < 10) failNow("starve_grants");
    inst_req = 1'b0;
    data_req = 1'b0;
    mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    mem_ready = 1'b0;
  endtask

  task automatic resetTest();
    int cyc;
    vec_t v;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0300;
    mem_ready = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_req && cyc < 5);
    chk("rst_req_before", 32'(mem_req), 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_async_req", 32'(mem_req), 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    data_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", {30'h0, inst_done, data_done}, 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_after_done", {30'h0, inst_done, data_done}, 32'h0);
    v = '{isData: 1'b0, wr: 1'b0, strb: 4'h0, addr: 32'hBFC0_0010, wdata: 32'h0,
          waitCyc: 1, memRd: 32'h0123_4567, expLat: 3, expRd: 32'h0123_4567};
    runOne(v);
  endtask

  // Load, ready in its first mem_req cycle, request renewed in the done cycle
  task automatic backToBack();
    mem_ready = 1'b1;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0500;
    mem_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("b2b_req1", 32'(mem_req), 32'h1);
    chk("b2b_addr1", mem_addr, 32'h0000_0500);
    @(negedge clk);
    chk("b2b_done1", 32'(data_done), 32'h1);
    chk("b2b_rdata1", data_rdata, 32'h1111_2222);
    chk("b2b_req_resp", 32'(mem_req), 32'h0);
    data_addr = 32'h0000_0504;
    mem_rdata = 32'h3333_4444;
    @(negedge clk);
    chk("b2b_idle_req", 32'(mem_req), 32'h0);
    chk("b2b_idle_done", 32'(data_done), 32'h0);
    @(negedge clk);
    chk("b2b_req2", 32'(mem_req), 32'h1);
    chk("b2b_addr2", mem_addr, 32'h0000_0504);
    @(negedge clk);
    chk("b2b_done2", 32'(data_done), 32'h1);
    chk("b2b_rdata2", data_rdata, 32'h3333_4444);
    data_req = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("b2b_single_done", 32'(data_done), 32'h0);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic timeoutTest();
    int hi;
    int cyc;
    bit seen;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0400;
    mem_ready = 1'b0;
    hi = 0; cyc = 0; seen = 1'b0;
    while (cyc < 40 && !(seen && !mem_req)) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        seen = 1'b1;
        hi++;
      end
    end
    if (!(seen && !mem_req)) failNow("to_drop");
    chk("to_req_cycles", 32'(hi), 32'd8);
    chk("to_data_done", 32'(data_done), 32'h1);
    chk("to_mem_err", 32'(mem_err), 32'h1);
    chk("to_data_rdata", data_rdata, 32'h0);
    data_req = 1'b0;
    @(negedge clk);
    chk("to_err_pulse", 32'(mem_err), 32'h0);
  endtask
`endif

  // Random traffic against a transaction-level model. The model tracks
  // whether the port is free, busy with one access, or answering. It also
  // tracks the starvation count as defined by the grant rules.
  task automatic randomTest(input int cycles);
    bit iPend = 1'b0, dPend = 1'b0;
    bit memActive = 1'b0;
    int waitLeft = 0;
    bit busy = 1'b0, answering = 1'b0, ownerData = 1'b0;
    int starve = 0;
    bit eReq = 1'b0, eInstDone = 1'b0, eDataDone = 1'b0, eWr = 1'b0;
    logic [3:0]  eStrb = 4'h0;
    logic [31:0] eAddr = 32'h0, eWdata = 32'h0;
    logic [31:0] eInstRd = 32'h0, eDataRd = 32'h0;
    for (int c = 0; c < cycles; c++) begin
      // requesters: hold until done, then maybe start a new access
      if (inst_done) iPend = 1'b0;
      if (data_done) dPend = 1'b0;
      if (!iPend && $urandom_range(0, 2) == 0) begin
        iPend = 1'b1;
        inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dPend && $urandom_range(0, 2) == 0) begin
        dPend = 1'b1;
        data_wr = 1'($urandom_range(0, 1));
        data_wstrb = 4'($urandom_range(0, 15));
        data_addr = $urandom & 32'hFFFF_FFFC;
        data_wdata = $urandom;
      end
      inst_req = iPend;
      data_req = dPend;
      // memory: random wait of 0..3 cycles; stray ready outside accesses
      mem_rdata = $urandom;
      if (mem_req) begin
        if (!memActive) begin
          memActive = 1'b1;
          waitLeft = $urandom_range(0, 3);
        end
        if (waitLeft == 0) begin
          mem_ready = 1'b1;
          memActive = 1'b0;
        end else begin
          mem_ready = 1'b0;
          waitLeft--;
        end
      end else begin
        memActive = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
      end
      // model: expected outputs for the next cycle
      eInstDone = 1'b0;
      eDataDone = 1'b0;
      if (answering) begin
        answering = 1'b0;
        eReq = 1'b0;
      end else if (busy) begin
        if (mem_ready) begin
          busy = 1'b0;
          answering = 1'b1;
          eReq = 1'b0;
          if (ownerData) begin
            eDataDone = 1'b1;
            if (!eWr) eDataRd = mem_rdata;
          end else begin
            eInstDone = 1'b1;
            eInstRd = mem_rdata;
          end
        end
      end else begin
        if (data_req && !(inst_req && starve >= LIMIT)) begin
          busy = 1'b1; ownerData = 1'b1; eReq = 1'b1;
          eWr = data_wr; eStrb = data_wr ? data_wstrb : 4'h0;
          eAddr = data_addr; eWdata = data_wdata;
          starve = inst_req ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
        end else if (inst_req) begin
          busy = 1'b1; ownerData = 1'b0; eReq = 1'b1;
          eWr = 1'b0; eStrb = 4'h0; eAddr = inst_addr;
          starve = 0;
        end else begin
          starve = 0;
        end
      end
      @(negedge clk);
      chk("rnd_mem_req", 32'(mem_req), 32'(eReq));
      if (eReq) begin
        chk("rnd_mem_addr", mem_addr, eAddr);
        chk("rnd_mem_wr", 32'(mem_wr), 32'(eWr));
        chk("rnd_mem_wstrb", 32'(mem_wstrb), 32'(eStrb));
        if (eWr) chk("rnd_mem_wdata", mem_wdata, eWdata);
      end
      chk("rnd_inst_done", 32'(inst_done), 32'(eInstDone));
      chk("rnd_data_done", 32'(data_done), 32'(eDataDone));
      chk("rnd_inst_rdata", inst_rdata, eInstRd);
      chk("rnd_data_rdata", data_rdata, eDataRd);
      chk("rnd_mem_err", 32'(mem_err), 32'h0);
    end
    inst_req = 1'b0;
    data_req = 1'b0;
  endtask

  initial begin
    tbl[0] = '{isData: 1'b0, wr: 1'b0, strb: 4'h0, addr: 32'hBFC0_0000, wdata: 32'h0,
               waitCyc: 0, memRd: 32'h2408_0001, expLat: 2, expRd: 32'h2408_0001};
    tbl[1] = '{isData: 1'b1, wr: 1'b0, strb: 4'hF, addr: 32'h0000_0100, wdata: 32'h1111_1111,
               waitCyc: 1, memRd: 32'h1357_2468, expLat: 3, expRd: 32'h1357_2468};
    tbl[2] = '{isData: 1'b1, wr: 1'b1, strb: 4'b0011, addr: 32'h0000_0080, wdata: 32'hA5A5_A5A5,
               waitCyc: 3, memRd: 32'hDEAD_BEEF, expLat: 5, expRd: 32'h1357_2468};
    tbl[3] = '{isData: 1'b0, wr: 1'b0, strb: 4'h0, addr: 32'hBFC0_0004, wdata: 32'h0,
               waitCyc: 2, memRd: 32'h8C09_0010, expLat: 4, expRd: 32'h8C09_0010};
    tbl[4] = '{isData: 1'b1, wr: 1'b0, strb: 4'h0, addr: 32'hFFFF_FFFC, wdata: 32'h0,
               waitCyc: 0, memRd: 32'hCAFE_F00D, expLat: 2, expRd: 32'hCAFE_F00D};

    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_mem_req", 32'(mem_req), 32'h0);
    chk("reset_done", {30'h0, inst_done, data_done}, 32'h0);
    chk("reset_inst_rdata", inst_rdata, 32'h0);
    chk("reset_data_rdata", data_rdata, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) runOne(tbl[i]);
    starveTest();
    resetTest();
    backToBack();
`ifdef MEM_ARB_TIMEOUT_EN
    timeoutTest();
`endif

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    randomTest(3000);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
